// File: rtl/gemm_pkg.sv
// rtl/gemm_pkg.sv - shared types and defaults for the GeMM tile sequencer
// Contents: gemm_tile_state_t (sequencer states), DefaultAddrWidth (config/counter width).
package gemm_pkg;

    localparam int unsigned DefaultAddrWidth = 16;

    typedef enum logic [1:0] {
        TileIdle,
        TileBusy,
        TileDrain,
        TileFinish
    } gemm_tile_state_t;

endpackage

// File: rtl/ceiling_counter.sv
// rtl/ceiling_counter.sv - counter that wraps to zero at a runtime ceiling
// Ports: clk_i/rst_ni (async active-low), clr_i (sync clear, wins over en_i),
//        en_i (advance), ceiling_i (count range 0..ceiling-1),
//        count_o (current value), at_ceil_o (count_o is the last value of the range).
module ceiling_counter import gemm_pkg::*; #(
    parameter int unsigned Width      = DefaultAddrWidth,
    parameter bit          HasCeiling = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [Width-1:0] ceiling_i,
    output logic [Width-1:0] count_o,
    output logic             at_ceil_o
);

    logic [Width-1:0] count_d, count_q;
    logic             at_ceil;

    // Without a ceiling the counter simply rolls over at all-ones.
    assign at_ceil = HasCeiling ? (count_q == (ceiling_i - Width'(1))) : (&count_q);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = at_ceil ? '0 : count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign at_ceil_o = at_ceil;

endmodule

// File: rtl/gemm_tile_sequencer.sv
// rtl/gemm_tile_sequencer.sv - walks an M x N tile grid, K input beats per tile
// Ports: clk_i/rst_ni (async active-low); start_i + cfg_M_i/cfg_N_i/cfg_K_i (job launch,
//        sampled in Idle); input_valid_i/input_ready_o (operand beats); acc_clr_o (first beat
//        of a tile); result_valid_o/result_ready_i (tile result); busy_o, done_o (job status);
//        M_count_o/N_count_o/K_count_o (position). With GEMM_TILE_PERF_EN defined an extra
//        stall_cnt_o[31:0] output counts stalled Busy/Drain cycles (saturating).
module gemm_tile_sequencer import gemm_pkg::*; #(
    parameter int unsigned AddrWidth = DefaultAddrWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] cfg_M_i,
    input  logic [AddrWidth-1:0] cfg_N_i,
    input  logic [AddrWidth-1:0] cfg_K_i,
    input  logic                 input_valid_i,
    output logic                 input_ready_o,
    output logic                 acc_clr_o,
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [AddrWidth-1:0] M_count_o,
    output logic [AddrWidth-1:0] N_count_o,
    output logic [AddrWidth-1:0] K_count_o
`ifdef GEMM_TILE_PERF_EN
    ,
    output logic [31:0]          stall_cnt_o
`endif
);

    gemm_tile_state_t     state_d, state_q;
    logic [AddrWidth-1:0] cfg_m_d, cfg_m_q, cfg_n_d, cfg_n_q, cfg_k_d, cfg_k_q;
    logic                 input_ready_d, input_ready_q;
    logic                 result_valid_d, result_valid_q;
    logic                 busy_d, busy_q;
    logic                 done_d, done_q;

    logic start_acc, cfg_zero, beat_acc, res_hs, last_tile;
    logic cnt_clr, n_en, m_en;
    logic k_at_ceil, n_at_ceil, m_at_ceil;

    assign start_acc = (state_q == TileIdle) & start_i;
    assign cfg_zero  = (cfg_M_i == '0) | (cfg_N_i == '0) | (cfg_K_i == '0);
    assign beat_acc  = input_valid_i & input_ready_q;
    assign res_hs    = result_valid_q & result_ready_i;
    assign last_tile = m_at_ceil & n_at_ceil;

    // Clearing on the final handshake makes the counters read zero during Finish.
    assign cnt_clr = start_acc | (res_hs & last_tile);
    assign n_en    = res_hs & ~last_tile;
    assign m_en    = n_en & n_at_ceil;

    ceiling_counter #(.Width(AddrWidth), .HasCeiling(1'b1)) u_k_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (cnt_clr),
        .en_i      (beat_acc),
        .ceiling_i (cfg_k_q),
        .count_o   (K_count_o),
        .at_ceil_o (k_at_ceil)
    );

    ceiling_counter #(.Width(AddrWidth), .HasCeiling(1'b1)) u_n_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (cnt_clr),
        .en_i      (n_en),
        .ceiling_i (cfg_n_q),
        .count_o   (N_count_o),
        .at_ceil_o (n_at_ceil)
    );

    ceiling_counter #(.Width(AddrWidth), .HasCeiling(1'b1)) u_m_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (cnt_clr),
        .en_i      (m_en),
        .ceiling_i (cfg_m_q),
        .count_o   (M_count_o),
        .at_ceil_o (m_at_ceil)
    );

    always_comb begin
        state_d = state_q;
        cfg_m_d = cfg_m_q;
        cfg_n_d = cfg_n_q;
        cfg_k_d = cfg_k_q;
        unique case (state_q)
            TileIdle: begin
                if (start_i) begin
                    cfg_m_d = cfg_M_i;
                    cfg_n_d = cfg_N_i;
                    cfg_k_d = cfg_K_i;
                    state_d = cfg_zero ? TileFinish : TileBusy;
                end
            end
            TileBusy: begin
                if (beat_acc && k_at_ceil) state_d = TileDrain;
            end
            TileDrain: begin
                if (res_hs) state_d = last_tile ? TileFinish : TileBusy;
            end
            TileFinish: state_d = TileIdle;
            default:    state_d = TileIdle;
        endcase
        // Outputs are decoded from the next state so they are flops aligned with state_q.
        input_ready_d  = (state_d == TileBusy);
        result_valid_d = (state_d == TileDrain);
        busy_d         = (state_d != TileIdle);
        done_d         = (state_d == TileFinish);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= TileIdle;
            cfg_m_q        <= '0;
            cfg_n_q        <= '0;
            cfg_k_q        <= '0;
            input_ready_q  <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cfg_m_q        <= cfg_m_d;
            cfg_n_q        <= cfg_n_d;
            cfg_k_q        <= cfg_k_d;
            input_ready_q  <= input_ready_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign input_ready_o  = input_ready_q;
    assign result_valid_o = result_valid_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign acc_clr_o      = beat_acc & (K_count_o == '0);

`ifdef GEMM_TILE_PERF_EN
    logic [31:0] stall_cnt_d, stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_acc) begin
            stall_cnt_d = '0;
        end else if (((input_ready_q & ~input_valid_i) | (result_valid_q & ~result_ready_i))
                     && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// tb/tb_gemm_tile_sequencer.sv - randomized self-checking bench for gemm_tile_sequencer
module tb_gemm_tile_sequencer;

    localparam int AW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic [AW-1:0] cfg_M_i = '0;
    logic [AW-1:0] cfg_N_i = '0;
    logic [AW-1:0] cfg_K_i = '0;
    logic          input_valid_i = 1'b0;
    logic          input_ready_o;
    logic          acc_clr_o;
    logic          result_valid_o;
    logic          result_ready_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic [AW-1:0] M_count_o;
    logic [AW-1:0] N_count_o;
    logic [AW-1:0] K_count_o;
`ifdef GEMM_TILE_PERF_EN
    logic [31:0]   stall_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    gemm_tile_sequencer #(.AddrWidth(AW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .cfg_M_i        (cfg_M_i),
        .cfg_N_i        (cfg_N_i),
        .cfg_K_i        (cfg_K_i),
        .input_valid_i  (input_valid_i),
        .input_ready_o  (input_ready_o),
        .acc_clr_o      (acc_clr_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .M_count_o      (M_count_o),
        .N_count_o      (N_count_o),
        .K_count_o      (K_count_o)
`ifdef GEMM_TILE_PERF_EN
        ,
        .stall_cnt_o    (stall_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, input_ready_o, 0);
        check({tag, "_clr"},   acc_clr_o, 0);
        check({tag, "_rv"},    result_valid_o, 0);
        check({tag, "_busy"},  busy_o, 0);
        check({tag, "_done"},  done_o, 0);
        check({tag, "_m"},     M_count_o, 0);
        check({tag, "_n"},     N_count_o, 0);
        check({tag, "_k"},     K_count_o, 0);
    endtask

    // Reference: a job is the list of tiles 0..M*N-1 in row-major order, each needing K beats.
    // The bench tracks which tile/beat it is on, whether a result is owed, and whether the
    // job has ended, and derives every expected output from those facts.
    // vhold/rhold: total cycles to force valid/ready low while the DUT waits on them.
    // abort_tiles >= 0: pull reset once that many results have been handed over.
    task automatic run_job(input int m, input int n, input int k, input int vpct, input int rpct,
                           input int vhold, input int rhold, input int abort_tiles,
                           input int exp_stall);
        int  tile, beat, results, beats, dones, cyc, total, stall, vh, rh;
        bit  pending, fin, ended, zero, acc, hs;
        tile = 0; beat = 0; results = 0; beats = 0; dones = 0; cyc = 0; stall = 0;
        pending = 0; ended = 0; vh = vhold; rh = rhold;
        zero  = (m == 0) || (n == 0) || (k == 0);
        total = zero ? 0 : m * n;

        @(posedge clk_i); #1;
        start_i = 1'b1;
        cfg_M_i = AW'(m); cfg_N_i = AW'(n); cfg_K_i = AW'(k);
        input_valid_i = 1'b1; result_ready_i = 1'b1;
        @(negedge clk_i);
        check("idle_ready", input_ready_o, 0);
        check("idle_busy", busy_o, 0);
        check("idle_clr", acc_clr_o, 0);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        // Config changes after the latch must have no effect.
        cfg_M_i = AW'($urandom); cfg_N_i = AW'($urandom); cfg_K_i = AW'($urandom);
        fin = zero;
        input_valid_i  = (vh > 0) ? 1'b0 : ($urandom_range(99) < vpct);
        if (vh > 0) vh--;
        result_ready_i = ($urandom_range(99) < rpct);

        while (!ended && cyc < 5000) begin
            @(negedge clk_i);
            cyc++;
            check("ready", input_ready_o, !pending && !fin);
            check("rvalid", result_valid_o, pending);
            check("done", done_o, fin);
            check("busy", busy_o, 1);
            if (fin) begin
                check("fin_m", M_count_o, 0);
                check("fin_n", N_count_o, 0);
                check("fin_k", K_count_o, 0);
`ifdef GEMM_TILE_PERF_EN
                check("stall_cnt", stall_cnt_o, stall);
                if (exp_stall >= 0) check("stall_directed", stall_cnt_o, exp_stall);
`endif
                dones++;
                ended = 1;
            end else begin
                check("m_cnt", M_count_o, tile / n);
                check("n_cnt", N_count_o, tile % n);
                check("k_cnt", K_count_o, beat);
                acc = input_valid_i && !pending;
                hs  = pending && result_ready_i;
                check("acc_clr", acc_clr_o, acc && (beat == 0));
                if (!pending && !input_valid_i) stall++;
                if (pending && !result_ready_i) stall++;
                if (acc) begin
                    beats++;
                    beat++;
                    if (beat == k) begin
                        beat = 0;
                        pending = 1;
                    end
                end else if (hs) begin
                    results++;
                    tile++;
                    pending = 0;
                    if (tile == total) fin = 1;
                end
            end
            if (abort_tiles >= 0 && results == abort_tiles && !fin) begin
                @(posedge clk_i); #1;
                rst_ni = 1'b0;
                start_i = 1'b0;
                #1;
                check_all_zero("abort");
                @(negedge clk_i);
                rst_ni = 1'b1;
                input_valid_i = 1'b0;
                return;
            end
            @(posedge clk_i); #1;
            if (ended) begin
                start_i = 1'b0;
                input_valid_i = 1'b1;
            end else begin
                // Stray starts mid-job must be ignored.
                start_i = ($urandom_range(9) == 0);
                cfg_M_i = AW'($urandom_range(3));
                if (vh > 0 && !pending && !fin) begin
                    input_valid_i = 1'b0;
                    vh--;
                end else begin
                    input_valid_i = ($urandom_range(99) < vpct);
                end
                if (rh > 0 && pending) begin
                    result_ready_i = 1'b0;
                    rh--;
                end else begin
                    result_ready_i = ($urandom_range(99) < rpct);
                end
            end
        end
        if (!ended) check("timeout", 0, 1);

        @(negedge clk_i);
        check("post_busy", busy_o, 0);
        check("post_done", done_o, 0);
        check("post_ready", input_ready_o, 0);
        check("post_rvalid", result_valid_o, 0);
        check("results", results, total);
        check("beats", beats, total * (zero ? 0 : k));
        check("done_once", dones, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        run_job(1, 1, 4, 100, 100, 0, 0, -1, -1);
        run_job(2, 3, 2, 100, 100, 0, 0, -1, -1);
        run_job(1, 2, 3, 100, 100, 0, 5, -1, -1);
        run_job(3, 2, 0, 100, 100, 0, 0, -1, -1);
        run_job(0, 2, 2, 100, 100, 0, 0, -1, -1);
        run_job(2, 1, 1, 70, 70, 0, 0, -1, -1);
        run_job(2, 3, 2, 100, 100, 0, 0, 3, -1);
        run_job(2, 3, 2, 80, 80, 0, 0, -1, -1);
        run_job(1, 1, 2, 100, 100, 7, 3, -1, 10);
        run_job(1, 1, 300, 90, 100, 0, 0, -1, -1);
        for (int i = 0; i < 10; i++) begin
            run_job($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 5),
                    $urandom_range(40, 100), $urandom_range(40, 100), 0, 0, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
